ctl_setup_fsm: RTL
==================

Name: ctl_setup_fsm

Overview:
Control-transfer sequencer for the default control pipe. It captures the 8-byte SETUP DATA0 payload from the USB packet decoder and presents the decoded request fields plus select/start to the downstream control pipe. It then tracks the DATA and STATUS stages and requests handshakes, ZLPs and STALLs from the TX path.

Parameters:
TIMEOUT_CYCLES, 60000, cycles without a token (while not IDLE) before aborting to IDLE; counter width = $clog2(TIMEOUT_CYCLES+1).
ERR_WINDOW, 3, cycles after start_o during which pipe_error_i is sampled.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
tok_recv_i  in  1  pulse: token addressed to this device received
tok_type_i  in  2  2'b00 OUT, 2'b01 IN, 2'b11 SETUP, 2'b10 ignored
tok_endp_i  in  4  token endpoint number
s_tvalid  in  1  RX data byte valid (sink always ready, no tready)
s_tlast  in  1  last byte of data packet (CRC already stripped)
s_tuser  in  1  with s_tlast: packet error (CRC/PID/bitstuff)
s_tdata  in  8  RX data byte
tx_done_i  in  1  pulse: host ACKed the last device-sent packet
pipe_error_i  in  1  downstream pipe rejected the request
select_o  out  1  control transfer in progress on EP0
start_o  out  1  one-cycle pulse: request fields valid and new
req_endpt_o  out  4  endpoint of the SETUP token
req_type_o  out  8  bmRequestType
req_args_o  out  8  bRequest
req_value_o  out  16  wValue (little-endian assembly)
req_index_o  out  16  wIndex
req_length_o  out  16  wLength
hsk_ack_o  out  1  pulse: send ACK
hsk_stall_o  out  1  pulse: send STALL
zlp_o  out  1  pulse: send zero-length DATA1
done_o  out  1  pulse: status stage completed

Behaviour:
- Reset: state IDLE; all outputs 0; req_* fields 0; byte counter 0; timeout counter 0.
- States: IDLE, SETUP_RX, DATA_IN, DATA_OUT, STATUS_IN, STATUS_OUT, STALL.
- A SETUP token to EP0 in any state (including mid-transfer) aborts the current transfer: drop select_o the next cycle, clear the byte counter, enter SETUP_RX. SETUP to a non-zero endpoint is ignored.
- SETUP_RX capture:
  - bytes are shifted into an 8-byte register; the counter saturates at 9.
  - On s_tlast with s_tuser=0 and count==8: latch fields (value/index/length = {byte[n+1], byte[n]}). Next cycle: hsk_ack_o=1, start_o=1, select_o=1.
  - Otherwise (error or count!=8): no ACK; return to IDLE with fields unchanged.
- Stage selection (same cycle as start_o):
  - length==0 -> STATUS_IN.
  - type[7]=1 -> DATA_IN.
  - else -> DATA_OUT.
- Error window: pipe_error_i high in any of the ERR_WINDOW cycles after start_o -> STALL. STALL is held until the next SETUP: every IN/OUT token to EP0 gives hsk_stall_o one cycle after tok_recv_i.
- DATA_IN: IN data is supplied by the downstream pipe. An OUT token to EP0 -> STATUS_OUT.
- DATA_OUT: each valid OUT data packet (s_tlast, s_tuser=0) -> hsk_ack_o. An IN token -> STATUS_IN.
- STATUS_IN:
  - IN token -> zlp_o one cycle later.
  - tx_done_i -> done_o, select_o=0, IDLE.
- STATUS_OUT: valid zero-length packet (s_tlast with count==0, s_tuser=0) -> hsk_ack_o, done_o, select_o=0, IDLE.
- Timeout: the counter clears on every tok_recv_i. Reaching TIMEOUT_CYCLES in any non-IDLE state -> IDLE, select_o=0, no pulses.
- Pulses are exactly one cycle wide. hsk_ack_o and hsk_stall_o are never asserted in the same cycle.
- Reset mid-transfer returns to IDLE and clears select_o the next cycle.

Decomposition:
- Shared package usb_ctl_pkg: token-type codes, standard bRequest codes (GET_DESCRIPTOR 8'h06, SET_ADDRESS 8'h05, SET_CONFIGURATION 8'h09, SET_INTERFACE 8'h0B), and the state encoding.
- One natural sub-module: ctl_setup_capture, the 8-byte shift register plus saturating byte counter, with a "valid setup" flag output.

Test Plan:
- GET_DESCRIPTOR SETUP {80 06 00 01 00 00 12 00} -> hsk_ack_o and start_o, type=8'h80, args=8'h06, value=16'h0100, length=16'h0012; state DATA_IN; OUT ZLP -> hsk_ack_o then done_o.
- SET_ADDRESS {00 05 07 00 00 00 00 00} -> start_o, STATUS_IN; IN token -> zlp_o; tx_done_i -> done_o, select_o=0.
- SETUP with 7 bytes, or 8 bytes with s_tuser=1 -> no hsk_ack_o, no start_o, state IDLE.
- pipe_error_i pulsed 2 cycles after start_o -> STALL; the next two IN tokens each give hsk_stall_o; a new valid SETUP clears it and gives hsk_ack_o.
- New SETUP arriving during DATA_IN -> select_o drops for at least one cycle, new fields latched, start_o pulses again.
- TIMEOUT_CYCLES=100, no tokens after start_o -> select_o=0 at cycle 100, with no done_o.

Source files
------------

// File: rtl/usb_ctl_pkg.sv
// Shared definitions for the EP0 control-transfer sequencer.
package usb_ctl_pkg;

  localparam int unsigned SETUP_BYTES = 8;
  localparam int unsigned SETUP_BITS  = SETUP_BYTES * 8;
  localparam int unsigned CNT_W       = 4;

  // Token PID classes as reported by the packet decoder (2'b10 is ignored)
  localparam logic [1:0] TOK_OUT   = 2'b00;
  localparam logic [1:0] TOK_IN    = 2'b01;
  localparam logic [1:0] TOK_SETUP = 2'b11;

  // Standard bRequest codes
  localparam logic [7:0] REQ_SET_ADDRESS       = 8'h05;
  localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'h06;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'h09;
  localparam logic [7:0] REQ_SET_INTERFACE     = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETUP_RX   = 3'd1,
    ST_DATA_IN    = 3'd2,
    ST_DATA_OUT   = 3'd3,
    ST_STATUS_IN  = 3'd4,
    ST_STATUS_OUT = 3'd5,
    ST_STALL      = 3'd6
  } ctl_state_e;

  typedef struct packed {
    logic [15:0] length;
    logic [15:0] index;
    logic [15:0] value;
    logic [7:0]  args;
    logic [7:0]  req_type;
  } setup_req_t;

  // Byte n of the SETUP payload lives at raw[8n+7:8n]; 16-bit fields are little-endian
  function automatic setup_req_t decode_setup(input logic [SETUP_BITS-1:0] raw);
    setup_req_t r;
    r.req_type = raw[7:0];
    r.args     = raw[15:8];
    r.value    = raw[31:16];
    r.index    = raw[47:32];
    r.length   = raw[63:48];
    return r;
  endfunction

endpackage

// File: rtl/ctl_setup_capture.sv
// 8-byte SETUP payload shift register with a saturating byte counter.
module ctl_setup_capture
  import usb_ctl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  input  logic [7:0]            s_tdata,
  output logic [SETUP_BITS-1:0] setup_raw_c,
  output logic                  setup_valid_c,
  output logic                  zlp_valid_c
);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SETUP_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SETUP_BYTES);

  logic [SETUP_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nxt;

  // Register contents and byte count including the byte on the bus this cycle
  always_comb begin
    setup_raw_c = shift_q;
    count_nxt   = count_q;
    if (s_tvalid) begin
      setup_raw_c = {s_tdata, shift_q[SETUP_BITS-1:8]};
      if (count_q != CNT_SAT) count_nxt = count_q + CNT_W'(1);
    end
  end

  assign setup_valid_c = s_tlast && !s_tuser && (count_nxt == CNT_FULL);
  assign zlp_valid_c   = s_tlast && !s_tuser && !s_tvalid && (count_q == '0);

  // Shift bytes in; counter restarts on each token and after each packet end
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      shift_q <= setup_raw_c;
      count_q <= s_tlast ? '0 : count_nxt;
    end
  end

endmodule

// File: rtl/ctl_setup_fsm.sv
// EP0 control-transfer sequencer: SETUP capture, stage tracking, handshake requests.
module ctl_setup_fsm
  import usb_ctl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 60000,
  parameter int unsigned ERR_WINDOW     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tok_recv_i,
  input  logic [1:0]  tok_type_i,
  input  logic [3:0]  tok_endp_i,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  input  logic        s_tuser,
  input  logic [7:0]  s_tdata,
  input  logic        tx_done_i,
  input  logic        pipe_error_i,
  output logic        select_o,
  output logic        start_o,
  output logic [3:0]  req_endpt_o,
  output logic [7:0]  req_type_o,
  output logic [7:0]  req_args_o,
  output logic [15:0] req_value_o,
  output logic [15:0] req_index_o,
  output logic [15:0] req_length_o,
  output logic        hsk_ack_o,
  output logic        hsk_stall_o,
  output logic        zlp_o,
  output logic        done_o
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned      ERR_W    = $clog2(ERR_WINDOW + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_LOAD = ERR_W'(ERR_WINDOW);

  ctl_state_e            state;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [ERR_W-1:0]      err_cnt;
  logic [SETUP_BITS-1:0] setup_raw_c;
  logic                  setup_valid_c;
  logic                  zlp_valid_c;
  logic                  tok_ep0_c;
  logic                  setup_tok_c;
  logic                  in_tok_c;
  logic                  out_tok_c;
  setup_req_t            req_c;

  assign tok_ep0_c   = tok_recv_i && (tok_endp_i == 4'd0);
  assign setup_tok_c = tok_ep0_c && (tok_type_i == TOK_SETUP);
  assign in_tok_c    = tok_ep0_c && (tok_type_i == TOK_IN);
  assign out_tok_c   = tok_ep0_c && (tok_type_i == TOK_OUT);
  assign req_c       = decode_setup(setup_raw_c);

  ctl_setup_capture u_capture (
    .clock         (clock),
    .reset         (reset),
    .clear         (tok_recv_i),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tuser       (s_tuser),
    .s_tdata       (s_tdata),
    .setup_raw_c   (setup_raw_c),
    .setup_valid_c (setup_valid_c),
    .zlp_valid_c   (zlp_valid_c)
  );

  // Control-transfer state machine with registered outputs and pulse requests
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      err_cnt      <= '0;
      select_o     <= 1'b0;
      start_o      <= 1'b0;
      req_endpt_o  <= '0;
      req_type_o   <= '0;
      req_args_o   <= '0;
      req_value_o  <= '0;
      req_index_o  <= '0;
      req_length_o <= '0;
      hsk_ack_o    <= 1'b0;
      hsk_stall_o  <= 1'b0;
      zlp_o        <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      start_o     <= 1'b0;
      hsk_ack_o   <= 1'b0;
      hsk_stall_o <= 1'b0;
      zlp_o       <= 1'b0;
      done_o      <= 1'b0;

      if (tok_recv_i || state == ST_IDLE) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + TMO_W'(1);

      // Error window opens on the cycle following the start pulse
      if (start_o)              err_cnt <= ERR_LOAD;
      else if (err_cnt != '0)   err_cnt <= err_cnt - ERR_W'(1);

      if (setup_tok_c) begin
        state       <= ST_SETUP_RX;
        select_o    <= 1'b0;
        err_cnt     <= '0;
        req_endpt_o <= tok_endp_i;
      end else if (state != ST_IDLE && !tok_recv_i && tmo_cnt == TMO_LAST) begin
        state    <= ST_IDLE;
        select_o <= 1'b0;
        err_cnt  <= '0;
        tmo_cnt  <= '0;
      end else if (err_cnt != '0 && pipe_error_i &&
                   state != ST_IDLE && state != ST_STALL) begin
        state   <= ST_STALL;
        err_cnt <= '0;
      end else begin
        case (state)
          ST_SETUP_RX: begin
            if (setup_valid_c) begin
              req_type_o   <= req_c.req_type;
              req_args_o   <= req_c.args;
              req_value_o  <= req_c.value;
              req_index_o  <= req_c.index;
              req_length_o <= req_c.length;
              hsk_ack_o    <= 1'b1;
              start_o      <= 1'b1;
              select_o     <= 1'b1;
              tmo_cnt      <= '0;
              if (req_c.length == 16'd0)  state <= ST_STATUS_IN;
              else if (req_c.req_type[7]) state <= ST_DATA_IN;
              else                        state <= ST_DATA_OUT;
            end else if (s_tlast) begin
              state <= ST_IDLE;
            end
          end
          ST_DATA_IN: begin
            if (out_tok_c) state <= ST_STATUS_OUT;
          end
          ST_DATA_OUT: begin
            if (s_tlast && !s_tuser) hsk_ack_o <= 1'b1;
            // The IN that ends the data stage is the status-stage IN: answer with a ZLP
            if (in_tok_c) begin
              state <= ST_STATUS_IN;
              zlp_o <= 1'b1;
            end
          end
          ST_STATUS_IN: begin
            if (in_tok_c) zlp_o <= 1'b1;
            if (tx_done_i) begin
              done_o   <= 1'b1;
              select_o <= 1'b0;
              state    <= ST_IDLE;
            end
          end
          ST_STATUS_OUT: begin
            if (zlp_valid_c) begin
              hsk_ack_o <= 1'b1;
              done_o    <= 1'b1;
              select_o  <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          ST_STALL: begin
            if (in_tok_c || out_tok_c) hsk_stall_o <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
